// File: rtl/fpu_ftoi_pipe.sv
// rtl/fpu_ftoi_pipe.sv - pipelined float-to-integer converter with rounding modes and saturation
// Optional feature macro: FPU_FTOI_NV_CNT_EN adds a saturating NV result counter.
module fpu_ftoi_pipe #(
   parameter int C_EXP    = 8,
   parameter int C_MANT   = 23,
   parameter int C_INT    = 32,
   parameter int C_STAGES = 2
) (
   input  logic                      Clk_CI,
   input  logic                      Rst_RI,
   input  logic                      Flush_SI,
   input  logic                      Valid_SI,
   output logic                      Ready_SO,
   input  logic [C_EXP+C_MANT:0]     Operand_DI,
   input  logic                      Signed_SI,
   input  logic [1:0]                RM_DI,
   output logic                      Valid_SO,
   input  logic                      Ready_SI,
   output logic [C_INT-1:0]          Result_DO,
   output logic                      NV_SO,
`ifdef FPU_FTOI_NV_CNT_EN
   input  logic                      NvCntClr_SI,
   output logic [15:0]               NvCnt_DO,
`endif
   output logic                      NX_SO
);

   localparam int FW   = C_MANT + 1;
   localparam int WW   = C_INT + FW;
   localparam int MW   = C_INT + 8;
   localparam int RW   = C_INT + 2;
   localparam int BIAS = (1 << (C_EXP - 1)) - 1;

   localparam logic [C_INT-1:0] MAXS = {1'b0, {(C_INT-1){1'b1}}};
   localparam logic [C_INT-1:0] MINS = {1'b1, {(C_INT-1){1'b0}}};
   localparam logic [C_INT:0]   HALF = {2'b01, {(C_INT-1){1'b0}}};

   // Unpack and align: FW fraction bits below the binary point cover the E = -1 case exactly.
   logic                a_sign, a_nan, a_ovf, a_guard, a_sticky;
   logic [C_EXP-1:0]    a_exp;
   logic [C_MANT-1:0]   a_frac;
   logic [C_MANT:0]     a_mant;
   logic [WW-1:0]       a_wide;
   logic [C_INT-1:0]    a_int;
   logic [MW-1:0]       mid_d;
   int                  a_e;

   always_comb begin
      a_sign   = Operand_DI[C_EXP+C_MANT];
      a_exp    = Operand_DI[C_MANT +: C_EXP];
      a_frac   = Operand_DI[C_MANT-1:0];
      a_mant   = {(a_exp != '0), a_frac};
      a_e      = ((a_exp == '0) ? 1 : int'(a_exp)) - BIAS;
      a_nan    = (&a_exp) & (a_frac != '0);
      a_ovf    = (&a_exp) | (a_e >= C_INT);
      a_wide   = '0;
      a_int    = '0;
      a_guard  = 1'b0;
      a_sticky = 1'b0;
      if (a_e < -1) begin
         a_sticky = |a_mant;
      end else if (!a_ovf) begin
         a_wide   = WW'(a_mant) << (a_e + 1);
         a_int    = a_wide[WW-1:FW];
         a_guard  = a_wide[FW-1];
         a_sticky = |a_wide[FW-2:0];
      end
      mid_d = {a_sign, a_nan, a_ovf, a_int, a_guard, a_sticky, Signed_SI, RM_DI};
   end

   function automatic logic [RW-1:0] round_sat(input logic [MW-1:0] m);
      logic             sgn, nan, ovf, g, s, smode, inc, nv, nx;
      logic [1:0]       rm;
      logic [C_INT-1:0] ip, res;
      logic [C_INT:0]   mag;
      {sgn, nan, ovf, ip, g, s, smode, rm} = m;
      case (rm)
         2'b00:   inc = g & (s | ip[0]);
         2'b01:   inc = 1'b0;
         2'b10:   inc = sgn & (g | s);
         default: inc = ~sgn & (g | s);
      endcase
      mag = {1'b0, ip} + {{C_INT{1'b0}}, inc};
      nv  = 1'b1;
      res = '0;
      if (nan) begin
         res = smode ? MAXS : '1;
      end else if (ovf) begin
         if (smode) res = sgn ? MINS : MAXS;
         else       res = sgn ? '0 : '1;
      end else if (smode) begin
         if (sgn) begin
            // -2^(C_INT-1) is the one magnitude that only fits on the negative side
            if (mag > HALF) begin
               res = MINS;
            end else begin
               nv  = 1'b0;
               res = -mag[C_INT-1:0];
            end
         end else if (mag >= HALF) begin
            res = MAXS;
         end else begin
            nv  = 1'b0;
            res = mag[C_INT-1:0];
         end
      end else if (sgn) begin
         nv = (mag != '0);
      end else if (mag[C_INT]) begin
         res = '1;
      end else begin
         nv  = 1'b0;
         res = mag[C_INT-1:0];
      end
      nx = (g | s) & ~nv;
      return {res, nv, nx};
   endfunction

   logic [C_STAGES-1:0] vld_q, vld_d, adv;
   logic [RW-1:0]       out_res;
   logic                rdy_q;

   for (genvar k = 0; k < C_STAGES; k++) begin : g_ctl
      assign adv[k] = Ready_SI | ~(&vld_q[C_STAGES-1:k]);
      if (k == 0) begin : g_in
         assign vld_d[k] = Flush_SI ? 1'b0 : (adv[k] ? (Valid_SI & Ready_SO) : vld_q[k]);
      end else begin : g_mid
         assign vld_d[k] = Flush_SI ? 1'b0 : (adv[k] ? vld_q[k-1] : vld_q[k]);
      end
   end

   assign Ready_SO = rdy_q & adv[0] & ~Flush_SI;

   always_ff @(posedge Clk_CI or posedge Rst_RI) begin
      if (Rst_RI) begin
         vld_q <= '0;
         rdy_q <= 1'b0;
      end else begin
         vld_q <= vld_d;
         rdy_q <= 1'b1;
      end
   end

   if (C_STAGES == 1) begin : g_one
      logic [RW-1:0] res_q;
      always_ff @(posedge Clk_CI or posedge Rst_RI) begin
         if (Rst_RI) res_q <= '0;
         else if (adv[0] & ~Flush_SI) res_q <= round_sat(mid_d);
      end
      assign out_res = res_q;
   end else begin : g_multi
      logic [MW-1:0] mid_q;
      logic [RW-1:0] res_q [1:C_STAGES-1];
      always_ff @(posedge Clk_CI or posedge Rst_RI) begin
         if (Rst_RI) begin
            mid_q <= '0;
            for (int k = 1; k < C_STAGES; k++) res_q[k] <= '0;
         end else begin
            if (adv[0] & ~Flush_SI) mid_q <= mid_d;
            if (adv[1] & ~Flush_SI) res_q[1] <= round_sat(mid_q);
            for (int k = 2; k < C_STAGES; k++)
               if (adv[k] & ~Flush_SI) res_q[k] <= res_q[k-1];
         end
      end
      assign out_res = res_q[C_STAGES-1];
   end

   assign Valid_SO  = vld_q[C_STAGES-1];
   assign Result_DO = out_res[RW-1:2];
   assign NV_SO     = out_res[1];
   assign NX_SO     = out_res[0];

`ifdef FPU_FTOI_NV_CNT_EN
   logic [15:0] nv_cnt_q, nv_cnt_d;

   always_comb begin
      nv_cnt_d = nv_cnt_q;
      if (NvCntClr_SI) nv_cnt_d = '0;
      else if (Valid_SO & Ready_SI & NV_SO & (nv_cnt_q != 16'hFFFF)) nv_cnt_d = nv_cnt_q + 16'd1;
   end

   always_ff @(posedge Clk_CI or posedge Rst_RI) begin
      if (Rst_RI) nv_cnt_q <= '0;
      else        nv_cnt_q <= nv_cnt_d;
   end

   assign NvCnt_DO = nv_cnt_q;
`endif

endmodule

// File: tb/tb_fpu_ftoi_pipe.sv
// tb/tb_fpu_ftoi_pipe.sv - self-checking bench for fpu_ftoi_pipe (3-stage, binary32 to 32-bit)
module tb_fpu_ftoi_pipe;
   logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, vin = 1'b0, sm = 1'b0, rdy_in = 1'b0;
   logic [31:0] op = '0;
   logic [1:0]  rm = '0;
   logic        rdy_o, vout, nv, nx;
   logic [31:0] res;
`ifdef FPU_FTOI_NV_CNT_EN
   logic        cnt_clr = 1'b0;
   logic [15:0] cnt;
`endif

   int          errors = 0, checks = 0;
   logic [33:0] q[$];
   logic [33:0] cur_exp = '0, hold_val = '0, e;
   logic        hold_v = 1'b0, acc = 1'b0;
   int          lat;

   logic [31:0] d_op [16] = '{32'h3FC00000, 32'h3FC00000, 32'h40200000, 32'h40200000,
                              32'hC0200000, 32'h4F000000, 32'hCF000000, 32'h7FC00000,
                              32'hBF800000, 32'hBF000000, 32'h00000001, 32'h80000000,
                              32'hFF800000, 32'h4F7FFFFF, 32'h4F800000, 32'hBF000000};
   logic        d_sm [16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
   logic [1:0]  d_rm [16] = '{2'd0, 2'd1, 2'd0, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0,
                              2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2};
   logic [33:0] d_exp [16] = '{{32'h00000002, 2'b01}, {32'h00000001, 2'b01},
                               {32'h00000002, 2'b01}, {32'h00000003, 2'b01},
                               {32'hFFFFFFFD, 2'b01}, {32'h7FFFFFFF, 2'b10},
                               {32'h80000000, 2'b00}, {32'hFFFFFFFF, 2'b10},
                               {32'h00000000, 2'b10}, {32'h00000000, 2'b01},
                               {32'h00000001, 2'b01}, {32'h00000000, 2'b00},
                               {32'h80000000, 2'b10}, {32'hFFFFFF00, 2'b00},
                               {32'hFFFFFFFF, 2'b10}, {32'hFFFFFFFF, 2'b01}};

   always #5 clk = ~clk;

   fpu_ftoi_pipe #(.C_EXP(8), .C_MANT(23), .C_INT(32), .C_STAGES(3)) dut (
      .Clk_CI(clk), .Rst_RI(rst), .Flush_SI(flush), .Valid_SI(vin), .Ready_SO(rdy_o),
      .Operand_DI(op), .Signed_SI(sm), .RM_DI(rm), .Valid_SO(vout), .Ready_SI(rdy_in),
      .Result_DO(res), .NV_SO(nv),
`ifdef FPU_FTOI_NV_CNT_EN
      .NvCntClr_SI(cnt_clr), .NvCnt_DO(cnt),
`endif
      .NX_SO(nx));

   // Exact real-valued conversion: binary32 values and 32-bit integers are exact in double.
   function automatic logic [33:0] model(input logic [31:0] f, input logic smode, input logic [1:0] rmode);
      int          ex;
      real         v, r, fl, d;
      logic [31:0] rv;
      logic        fnv, fnx;
      longint      li;
      ex  = int'(f[30:23]);
      fnv = 1'b0;
      rv  = '0;
      if (ex == 255 && f[22:0] != 0) return {smode ? 32'h7FFFFFFF : 32'hFFFFFFFF, 2'b10};
      if (ex == 255) v = 1.0e40;
      else v = (real'(f[22:0]) + ((ex == 0) ? 0.0 : 8388608.0)) * (2.0 ** real'(((ex == 0) ? 1 : ex) - 150));
      if (f[31]) v = -v;
      fl = $floor(v);
      d  = v - fl;
      case (rmode)
         2'd0:    r = (d > 0.5 || (d == 0.5 && $floor(fl / 2.0) * 2.0 != fl)) ? fl + 1.0 : fl;
         2'd1:    r = (v < 0.0) ? $ceil(v) : fl;
         2'd2:    r = fl;
         default: r = $ceil(v);
      endcase
      li = longint'(r);
      if (smode) begin
         if (r > 2147483647.0) begin fnv = 1'b1; rv = 32'h7FFFFFFF; end
         else if (r < -2147483648.0) begin fnv = 1'b1; rv = 32'h80000000; end
         else rv = li[31:0];
      end else begin
         if (r > 4294967295.0) begin fnv = 1'b1; rv = 32'hFFFFFFFF; end
         else if (r < 0.0) begin fnv = 1'b1; rv = '0; end
         else rv = li[31:0];
      end
      fnx = (r != v) && !fnv;
      return {rv, fnv, fnx};
   endfunction

   task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One clock: sample at negedge, score transfers, then return just after the posedge.
   task automatic step();
      @(negedge clk);
      if (vout && !rdy_in) begin
         if (hold_v) check("hold_stable", {res, nv, nx}, hold_val);
         hold_v   = 1'b1;
         hold_val = {res, nv, nx};
      end else begin
         hold_v = 1'b0;
      end
      if (vout && rdy_in) begin
         if (q.size() == 0) begin
            check("unexpected_out", 34'(vout), 34'd0);
         end else begin
            e = q.pop_front();
            check("result", 34'(res), 34'(e[33:2]));
            check("nv", 34'(nv), 34'(e[1]));
            check("nx", 34'(nx), 34'(e[0]));
         end
      end
      acc = vin && rdy_o;
      if (acc) q.push_back(cur_exp);
      @(posedge clk);
      #1;
   endtask

   task automatic new_op();
      int         sel;
      logic [7:0] ex;
      sel = $urandom_range(0, 9);
      if (sel == 0)      ex = 8'h00;
      else if (sel == 1) ex = 8'hFF;
      else               ex = 8'($urandom_range(110, 165));
      op = {1'($urandom), ex, 23'($urandom)};
      if ($urandom_range(0, 4) == 0) op[22:0] = 23'h0;
      sm = 1'($urandom);
      rm = 2'($urandom);
      cur_exp = model(op, sm, rm);
   endtask

   task automatic drain();
      vin    = 1'b0;
      rdy_in = 1'b1;
      for (int i = 0; i < 50 && q.size() != 0; i++) step();
      check("drain_empty", 34'(q.size()), 34'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 34'(vout), 34'd0);
      check("rst_result", 34'(res), 34'd0);
      check("rst_nv", 34'(nv), 34'd0);
      check("rst_nx", 34'(nx), 34'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_ready", 34'(rdy_o), 34'd1);

      rdy_in = 1'b1;
      vin    = 1'b1;
      for (int i = 0; i < 16; i++) begin
         op = d_op[i]; sm = d_sm[i]; rm = d_rm[i]; cur_exp = d_exp[i];
         acc = 1'b0;
         for (int t = 0; t < 20 && !acc; t++) step();
         check("accept_dir", 34'(acc), 34'd1);
      end
      drain();

      op = d_op[3]; sm = d_sm[3]; rm = d_rm[3]; cur_exp = d_exp[3];
      vin = 1'b1;
      step();
      vin = 1'b0;
      lat = 1;
      while (!vout && lat < 10) begin step(); lat++; end
      check("latency", 34'(lat), 34'd3);
      drain();

      acc = 1'b1; vin = 1'b1; rdy_in = 1'b0;
      for (int i = 0; i < 8; i++) begin if (acc) new_op(); step(); end
      check("ready_full", 34'(rdy_o), 34'd0);
      rdy_in = 1'b1;
      for (int i = 0; i < 6; i++) begin if (acc) new_op(); step(); end
      drain();

      acc = 1'b1; vin = 1'b1; rdy_in = 1'b0;
      for (int i = 0; i < 2; i++) begin if (acc) new_op(); step(); end
      if (acc) new_op();
      flush = 1'b1;
      #1;
      check("flush_ready", 34'(rdy_o), 34'd0);
      step();
      flush = 1'b0;
      q.delete();
      check("flush_valid", 34'(vout), 34'd0);
      vin = 1'b0; rdy_in = 1'b1;
      for (int i = 0; i < 6; i++) step();
      check("flush_empty", 34'(q.size()), 34'd0);

      acc = 1'b1; vin = 1'b1; rdy_in = 1'b0;
      for (int i = 0; i < 4; i++) begin if (acc) new_op(); step(); end
      rst = 1'b1;
      vin = 1'b0;
      #1;
      check("rst_mid_valid", 34'(vout), 34'd0);
      check("rst_mid_result", 34'(res), 34'd0);
      q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_mid_ready", 34'(rdy_o), 34'd1);

      acc = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (acc) new_op();
         vin    = ($urandom_range(0, 3) != 0);
         rdy_in = ($urandom_range(0, 2) != 0);
         step();
      end
      drain();

`ifdef FPU_FTOI_NV_CNT_EN
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      rdy_in  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         op = 32'h7FC00000; sm = 1'b1; rm = 2'd0; cur_exp = {32'h7FFFFFFF, 2'b10};
         vin = 1'b1; acc = 1'b0;
         for (int t = 0; t < 20 && !acc; t++) step();
      end
      drain();
      check("nvcnt_three", 34'(cnt), 34'd3);
      rdy_in = 1'b0; vin = 1'b1;
      op = 32'hBF800000; sm = 1'b0; rm = 2'd0; cur_exp = {32'h0, 2'b10};
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) step();
      vin = 1'b0;
      for (int t = 0; t < 20 && !vout; t++) step();
      check("nvcnt_pending", 34'(vout), 34'd1);
      cnt_clr = 1'b1;
      rdy_in  = 1'b1;
      step();
      cnt_clr = 1'b0;
      check("nvcnt_clr_prio", 34'(cnt), 34'd0);
      drain();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
